gamepad_command_queue: RTL

- Sits between the Gamepad reader and TemporizadorEntradas.
- Samples the 12-bit gamepad button vector once per video frame and debounces each bit over whole frames.
- Converts every new button press into a one-hot command and queues it in a small FIFO.
- Releases exactly one command per frame, so simultaneous presses are serialized and none is lost while the queue has room.

---
 rtl/gamepad_command_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gamepad_command_queue.sv
// Frame-synchronous gamepad front end: debounces buttons once per v_sync frame,
// turns new presses into one-hot commands and releases one command per frame.
module gcq_debounce_lane #(
    parameter int FRAMES = 2
) (
    input  logic Clock50,
    input  logic Reset,
    input  logic en,
    input  logic sample,
    output logic stable,
    output logic rise
);
    localparam int CNW = $clog2(FRAMES + 1);

    logic [CNW-1:0] cnt;
    logic [CNW-1:0] cnt_nxt;
    logic           qualify;

    assign cnt_nxt = cnt + CNW'(1);
    assign qualify = en && (sample != stable) && (cnt_nxt == CNW'(FRAMES));
    // Only presses produce events; a qualified release just clears the level.
    assign rise    = qualify & sample;

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (en) begin
            if (sample == stable) begin
                cnt <= '0;
            end else if (qualify) begin
                stable <= sample;
                cnt    <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end
endmodule

module gamepad_command_queue #(
    parameter int WIDTH            = 12,
    parameter int DEBOUNCE_FRAMES  = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic                            Clock50,
    input  logic                            Reset,
    input  logic                            v_sync,
    input  logic [WIDTH-1:0]                Botoes,
    input  logic                            clear_overflow,
    output logic [WIDTH-1:0]                Comando,
    output logic                            Comando_valid,
    output logic [WIDTH-1:0]                Pressionados,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int   PW      = $clog2(FIFO_DEPTH);
    localparam int   CW      = PW + 1;
    localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PUSH} state_t;

    state_t            state;
    logic [2:0]        vs_pipe;
    logic              tick;
    logic [WIDTH-1:0]  sample;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  ev;
    logic [WIDTH-1:0]  ev_lsb;
    logic [WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              fifo_full;
    logic              deb_en;

    // vs_pipe[1:0] is the synchronizer, vs_pipe[2] the edge register; idle level
    // at reset keeps reset release from looking like an edge on an idle line.
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) vs_pipe <= {3{VS_IDLE}};
        else        vs_pipe <= {vs_pipe[1:0], v_sync};
    end

    assign tick = (VSYNC_ACTIVE_LOW != 0) ? (vs_pipe[2] & ~vs_pipe[1])
                                          : (~vs_pipe[2] & vs_pipe[1]);

    assign deb_en = (state == S_DEBOUNCE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gcq_debounce_lane #(.FRAMES(DEBOUNCE_FRAMES)) u_lane (
            .Clock50 (Clock50),
            .Reset   (Reset),
            .en      (deb_en),
            .sample  (sample[i]),
            .stable  (stable[i]),
            .rise    (rise[i])
        );
    end

    assign Pressionados = stable;
    assign ev_lsb       = ev & (~ev + WIDTH'(1));
    assign fifo_full    = (fifo_count == CW'(FIFO_DEPTH));

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            state         <= S_IDLE;
            sample        <= '0;
            ev            <= '0;
            Comando       <= '0;
            Comando_valid <= 1'b0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            Comando_valid <= 1'b0;
            // A drop later in this block overrides the clear (set wins).
            if (clear_overflow) overflow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        sample <= Botoes;
                        state  <= S_DEBOUNCE;
                        if (fifo_count != '0) begin
                            Comando       <= mem[rd_ptr];
                            Comando_valid <= 1'b1;
                            rd_ptr        <= rd_ptr + PW'(1);
                            fifo_count    <= fifo_count - CW'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    ev    <= rise;
                    state <= S_PUSH;
                end
                S_PUSH: begin
                    if (ev == '0) begin
                        state <= S_IDLE;
                    end else begin
                        ev <= ev & ~ev_lsb;
                        if (fifo_full) begin
                            overflow <= 1'b1;
                        end else begin
                            mem[wr_ptr] <= ev_lsb;
                            wr_ptr      <= wr_ptr + PW'(1);
                            fifo_count  <= fifo_count + CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
